riscv_arb4_ctrl: RTL and testbench

//  Round-robin arbiter/sequencer sharing one resource (e.g. memory port) among 4 requesters.

---
 rtl/riscv_arb_pkg.sv | 30 +++
 rtl/riscv_rr_pick4.sv | 32 +++
 rtl/riscv_arb4_ctrl.sv | 162 ++++++++++++++++
 tb/tb_riscv_arb4_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// requester indices and a one-hot grant decode helper.
package riscv_arb_pkg;

  localparam int unsigned ARB_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] REQ0 = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;
  localparam logic [1:0] REQ3 = 2'd3;

  // Requester index to one-hot grant vector.
  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [ARB_N-1:0] oh;
    case (idx)
      REQ0:    oh = 4'b0001;
      REQ1:    oh = 4'b0010;
      REQ2:    oh = 4'b0100;
      REQ3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/riscv_rr_pick4.sv
// Combinational rotating-priority picker: the first set request bit found
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4) wins.
module riscv_rr_pick4
  import riscv_arb_pkg::*;
(
  input  logic [ARB_N-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic             any_o,
  output logic [1:0]       idx_o
);

  logic [1:0] try_s;
  logic       found_s;

  // Scan the four positions starting at the priority pointer.
  always_comb begin
    any_o   = |req_i;
    idx_o   = 2'd0;
    found_s = 1'b0;
    try_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      try_s = ptr_i + 2'(k);
      if (!found_s && req_i[try_s]) begin
        idx_o   = try_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/riscv_arb4_ctrl.sv
// Round-robin arbiter/sequencer sharing one resource among 4 requesters.
// A grant is held until the resource pulses done; priority then rotates to
// the requester after the one just served. Optional watchdog forced release
// is enabled by defining RISCV_ARB4_TIMEOUT_EN.
module riscv_arb4_ctrl
  import riscv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             i_riscv_arb4_clk,
  input  logic             i_riscv_arb4_rst_n,
  input  logic [ARB_N-1:0] i_riscv_arb4_req,
  input  logic             i_riscv_arb4_done,
  output logic [ARB_N-1:0] o_riscv_arb4_gnt,
  output logic [1:0]       o_riscv_arb4_sel,
  output logic             o_riscv_arb4_valid,
  output logic             o_riscv_arb4_timeout
);

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [ARB_N-1:0] gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             expire_s;
  logic             finish_s;
  logic             new_grant_s;
  logic [1:0]       arb_ptr_s;
  logic             pick_any_s;
  logic [1:0]       pick_idx_s;

  // Configuration guard: a counter too narrow to reach the limit is illegal.
  if ((2 ** CNT_W) < TIMEOUT_CYCLES) begin : g_cnt_w_too_small
  end

`ifdef RISCV_ARB4_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog: cleared on every new grant, counts BUSY cycles without done.
  always_comb begin
    expire_s  = (state_q == ST_BUSY) && (cnt_q == CNT_LIMIT);
    timeout_d = expire_s && !i_riscv_arb4_done;
    if (new_grant_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_BUSY) && !i_riscv_arb4_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_riscv_arb4_clk or negedge i_riscv_arb4_rst_n) begin
    if (!i_riscv_arb4_rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the watchdog, BUSY ends only on done and no timeout is reported.
  always_comb begin
    expire_s  = 1'b0;
    timeout_d = 1'b0;
  end
`endif

  // A transaction finishes on done (or forced release); the pointer used to
  // re-arbitrate then already points past the requester just served.
  always_comb begin
    finish_s = (state_q == ST_BUSY) && (i_riscv_arb4_done || expire_s);
    if (finish_s) begin
      arb_ptr_s = sel_q + 2'd1;
    end else begin
      arb_ptr_s = ptr_q;
    end
  end

  riscv_rr_pick4 u_pick (
    .req_i (i_riscv_arb4_req),
    .ptr_i (arb_ptr_s),
    .any_o (pick_any_s),
    .idx_o (pick_idx_s)
  );

  // FSM next state and grant/select/pointer updates; defaults hold everything.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    new_grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d     = ST_BUSY;
          gnt_d       = idx_to_onehot(pick_idx_s);
          sel_d       = pick_idx_s;
          valid_d     = 1'b1;
          new_grant_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (finish_s) begin
          ptr_d = arb_ptr_s;
          if (pick_any_s) begin
            state_d     = ST_BUSY;
            gnt_d       = idx_to_onehot(pick_idx_s);
            sel_d       = pick_idx_s;
            valid_d     = 1'b1;
            new_grant_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge i_riscv_arb4_clk or negedge i_riscv_arb4_rst_n) begin
    if (!i_riscv_arb4_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_riscv_arb4_gnt     = gnt_q;
  assign o_riscv_arb4_sel     = sel_q;
  assign o_riscv_arb4_valid   = valid_q;
  assign o_riscv_arb4_timeout = timeout_q;

endmodule

// File: tb/tb_riscv_arb4_ctrl.sv
// Scoreboard bench for riscv_arb4_ctrl: a transaction-level reference model
// (owner index, priority pointer, busy-cycle count) predicts the outputs for
// each cycle; a monitor pops and compares them on the falling edge.
module tb_riscv_arb4_ctrl;

  localparam int TO_LIM = 8;
`ifdef RISCV_ARB4_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  exp_t nxt;

  // Reference model state.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_cnt;

  riscv_arb4_ctrl #(.TIMEOUT_CYCLES(TO_LIM), .CNT_W(8)) dut (
    .i_riscv_arb4_clk     (clk),
    .i_riscv_arb4_rst_n   (rst_n),
    .i_riscv_arb4_req     (req),
    .i_riscv_arb4_done    (done),
    .o_riscv_arb4_gnt     (gnt),
    .o_riscv_arb4_sel     (sel),
    .o_riscv_arb4_valid   (valid),
    .o_riscv_arb4_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_cnt   = 0;
  endfunction

  // One clock of the arbitration rules; returns the outputs after the edge.
  function automatic exp_t model_step(input logic [3:0] r, input logic d);
    exp_t e;
    bit busy, expire, fin;
    busy   = (m_owner >= 0);
    expire = busy && TO_EN && (m_cnt == TO_LIM - 1);
    fin    = busy && (d || expire);
    e.timeout = expire && !d;
    if (!busy || fin) begin
      if (fin) m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_sel = m_owner;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
    end
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.valid = (m_owner >= 0);
    e.sel   = 2'(m_sel);
    return e;
  endfunction

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    nxt  = model_step(r, d);
    @(posedge clk);
    exp_q.push_back(nxt);
    #1;
  endtask

  // Monitor: compare each expected cycle against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",     int'(gnt),     int'(e.gnt));
      chk("sel",     int'(sel),     int'(e.sel));
      chk("valid",   int'(valid),   int'(e.valid));
      chk("timeout", int'(timeout), int'(e.timeout));
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt",   int'(gnt),   0);
    chk("rst_sel",   int'(sel),   0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_tmo",   int'(timeout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, done on cycle 4, then idle.
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);

    // Asynchronous reset in the middle of a grant to requester 2.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    @(negedge clk); #1;
    chk("pre_rst_gnt", int'(gnt), 4);
    rst_n = 1'b0;
    #1;
    chk("async_gnt",   int'(gnt),   0);
    chk("async_sel",   int'(sel),   0);
    chk("async_valid", int'(valid), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Rotation: all requesting, done every third cycle.
    for (int i = 0; i < 15; i++) step(4'b1111, (i % 3 == 2) ? 1'b1 : 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Drive pointer to 3, then wrap with requesters 3 and 0.
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b1);

    // Hold: winner drops its request mid-transaction.
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // Watchdog: no done at all, then done coinciding with the limit.
    for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < TO_LIM - 1; i++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
    end
    step(4'b0000, 1'b1);

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
